// File: rtl/lighting_controller_gen2.sv
// Room lighting controller: latches shade/lamp targets from a time code
// and ramps the shade position and lamp count toward them one step at a time.
module lighting_controller_gen2 #(
  parameter int NUM_LIGHTS = 16,
  parameter int LVL_W      = 4,
  parameter int RAMP_DIV   = 4,
  localparam int CNT_W     = $clog2(NUM_LIGHTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic [3:0]            tcode,
  input  logic [LVL_W-1:0]      ulight,
  input  logic [LVL_W-1:0]      length,
  output logic [LVL_W-1:0]      wshade,
  output logic [CNT_W-1:0]      lightnum,
  output logic [NUM_LIGHTS-1:0] lightstate,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = $clog2(RAMP_DIV);
  localparam int MW    = (LVL_W > CNT_W) ? LVL_W : CNT_W;

  localparam logic IDLE = 1'b0;
  localparam logic RAMP = 1'b1;

  localparam logic [LVL_W-1:0] SHADE_MAX = '1;
  localparam logic [MW-1:0]    NL_X      = MW'(NUM_LIGHTS);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(RAMP_DIV - 1);

  logic             state;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic [LVL_W-1:0] tgt_shade;
  logic [CNT_W-1:0] tgt_lights;

  logic [LVL_W-1:0] new_shade;
  logic [CNT_W-1:0] new_lights;
  logic [MW-1:0]    len_x;
  logic [MW-1:0]    half_x;

  logic             step;
  logic             at_tgt;
  logic [LVL_W-1:0] shade_step;
  logic [CNT_W-1:0] light_step;

  // Decode the time code into fresh targets; lamp count is clamped
  // to the number of lamps fitted, compared at full width.
  always_comb begin
    len_x      = MW'(length);
    half_x     = MW'(length >> 1);
    new_shade  = wshade;
    new_lights = '0;
    case (tcode)
      4'b0001: new_shade = SHADE_MAX;
      4'b0010: new_shade = ulight;
      4'b0100: begin
        new_shade  = '0;
        new_lights = CNT_W'((len_x < NL_X) ? len_x : NL_X);
      end
      4'b1000: begin
        new_shade  = '0;
        new_lights = CNT_W'((half_x < NL_X) ? half_x : NL_X);
      end
      default: ;
    endcase
  end

  // One-step move of each output toward its current target.
  always_comb begin
    step    = (div == DIV_LAST);
    div_nxt = step ? '0 : div + 1'b1;
    at_tgt  = (lightnum == tgt_lights) && (wshade == tgt_shade);

    light_step = lightnum;
    if (lightnum < tgt_lights)
      light_step = lightnum + 1'b1;
    else if (lightnum > tgt_lights)
      light_step = lightnum - 1'b1;

    shade_step = wshade;
    if (wshade < tgt_shade)
      shade_step = wshade + 1'b1;
    else if (wshade > tgt_shade)
      shade_step = wshade - 1'b1;
  end

  // Ramp FSM: retarget keeps the divider phase; req beats completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div        <= '0;
      tgt_shade  <= '0;
      tgt_lights <= '0;
      wshade     <= '0;
      lightnum   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state      <= RAMP;
            div        <= '0;
            tgt_shade  <= new_shade;
            tgt_lights <= new_lights;
          end
        end
        RAMP: begin
          if (!req && at_tgt) begin
            state <= IDLE;
            div   <= '0;
            done  <= 1'b1;
          end else begin
            div <= div_nxt;
            if (step) begin
              lightnum <= light_step;
              wshade   <= shade_step;
            end
            if (req) begin
              tgt_shade  <= new_shade;
              tgt_lights <= new_lights;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RAMP);

  // Thermometer view of the registered lamp count.
  for (genvar i = 0; i < NUM_LIGHTS; i++) begin : g_therm
    assign lightstate[i] = (lightnum > CNT_W'(i));
  end

endmodule

// File: tb/tb_lighting_controller_gen2.sv
// Bench for lighting_controller_gen2: directed corner cases plus
// random requests checked against an arithmetic trajectory model.
module tb_lighting_controller_gen2;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        req8 = 1'b0;
  logic [3:0]  tcode = '0;
  logic [3:0]  ulight = '0;
  logic [3:0]  length = '0;

  logic [3:0]  wshade;
  logic [4:0]  lightnum;
  logic [15:0] lightstate;
  logic        busy;
  logic        done;

  logic [3:0]  wshade8;
  logic [3:0]  lightnum8;
  logic [7:0]  lightstate8;
  logic        busy8;
  logic        done8;

  int errors = 0;
  int checks = 0;
  int ml = 0;
  int ms = 0;

  lighting_controller_gen2 dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .tcode(tcode), .ulight(ulight), .length(length),
    .wshade(wshade), .lightnum(lightnum),
    .lightstate(lightstate), .busy(busy), .done(done)
  );

  lighting_controller_gen2 #(.NUM_LIGHTS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8),
    .tcode(tcode), .ulight(ulight), .length(length),
    .wshade(wshade8), .lightnum(lightnum8),
    .lightstate(lightstate8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int el, input int es,
                         input int eb, input int ed);
    chk({tag, ".lightnum"}, 32'(lightnum), 32'(el));
    chk({tag, ".wshade"}, 32'(wshade), 32'(es));
    chk({tag, ".lightstate"}, 32'(lightstate), 32'((1 << el) - 1));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Issue one request from idle and follow the whole expected ramp.
  task automatic run_ramp(input string tag, input logic [3:0] tc,
                          input int ul, input int len);
    int tl, ts, dl, ds, n, st, el, es;
    ts = ms;
    tl = 0;
    case (tc)
      4'b0001: ts = 15;
      4'b0010: ts = ul;
      4'b0100: begin ts = 0; tl = imin(len, 16); end
      4'b1000: begin ts = 0; tl = imin(len / 2, 16); end
      default: ;
    endcase
    dl = (tl > ml) ? tl - ml : ml - tl;
    ds = (ts > ms) ? ts - ms : ms - ts;
    n = (dl > ds) ? dl : ds;
    tcode = tc;
    ulight = 4'(ul);
    length = 4'(len);
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int t = 0; t <= n * D + 1; t++) begin
      if (t > 0) tick();
      st = t / D;
      el = (tl >= ml) ? ml + imin(st, dl) : ml - imin(st, dl);
      es = (ts >= ms) ? ms + imin(st, ds) : ms - imin(st, ds);
      chk_all($sformatf("%s.t%0d", tag, t), el, es,
              (t <= n * D) ? 1 : 0, (t == n * D + 1) ? 1 : 0);
    end
    tick();
    chk_all({tag, ".after"}, tl, ts, 0, 0);
    ml = tl;
    ms = ts;
  endtask

  initial begin
    int waited;
    int r;
    logic [3:0] tc;

    // reset state
    repeat (2) tick();
    chk_all("rst", 0, 0, 0, 0);
    chk("rst.lightnum8", 32'(lightnum8), 0);
    rst_n = 1'b1;
    tick();
    chk_all("rst_rel", 0, 0, 0, 0);

    // morning from reset: 15 shade steps
    run_ramp("morning", 4'b0001, 0, 0);

    // evening len 4 from shade 15, then hold-shade retarget
    tcode = 4'b0100;
    length = 4'd4;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (32) tick();
    chk_all("ev4.k32", 4, 7, 1, 0);
    tcode = 4'b0011;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk_all("hold.k33", 4, 7, 1, 0);
    repeat (3) tick();
    chk_all("hold.k36", 3, 7, 1, 0);
    repeat (12) tick();
    chk_all("hold.k48", 0, 7, 1, 0);
    tick();
    chk_all("hold.k49", 0, 7, 0, 1);
    tick();
    chk_all("hold.k50", 0, 7, 0, 0);
    ml = 0;
    ms = 7;

    // evening len 4
    run_ramp("ev4", 4'b0100, 0, 4);

    // reset mid-ramp
    tcode = 4'b0001;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (9) tick();
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 0, 0, 0, 0);
    tick();
    chk_all("midrst.hold", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_all("midrst.rel", 0, 0, 0, 0);
    ml = 0;
    ms = 0;

    // evening len 8, retarget to night after 3 steps
    tcode = 4'b0100;
    length = 4'd8;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (12) tick();
    chk_all("rt.k12", 3, 0, 1, 0);
    tcode = 4'b1000;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (2) tick();
    chk_all("rt.k15", 3, 0, 1, 0);
    tick();
    chk_all("rt.k16", 4, 0, 1, 0);
    tick();
    chk_all("rt.k17", 4, 0, 0, 1);
    ml = 4;

    // retarget on a step edge uses the old targets
    tcode = 4'b0100;
    length = 4'd8;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (3) tick();
    tcode = 4'b0001;
    req = 1'b1;
    tick();
    req = 1'b0;
    chk_all("se.k4", 5, 0, 1, 0);
    repeat (4) tick();
    chk_all("se.k8", 4, 1, 1, 0);
    waited = 0;
    while (!done && waited < 100) begin
      tick();
      waited++;
    end
    chk("se.latency", 32'(waited), 32'd57);
    chk_all("se.end", 0, 15, 0, 1);
    ml = 0;
    ms = 15;

    // req coinciding with completion keeps the ramp alive
    tcode = 4'b0001;
    req = 1'b1;
    tick();
    chk_all("co.k0", 0, 15, 1, 0);
    tick();
    chk_all("co.k1", 0, 15, 1, 0);
    req = 1'b0;
    tick();
    chk_all("co.k2", 0, 15, 0, 1);

    // eight-lamp build saturates the count
    tcode = 4'b0100;
    length = 4'd15;
    req8 = 1'b1;
    tick();
    req8 = 1'b0;
    repeat (32) tick();
    chk("sat.lightnum", 32'(lightnum8), 32'd8);
    chk("sat.lightstate", 32'(lightstate8), 32'hff);
    chk("sat.done_early", 32'(done8), 32'd0);
    tick();
    chk("sat.done", 32'(done8), 32'd1);
    chk("sat.busy", 32'(busy8), 32'd0);
    chk("sat.wshade", 32'(wshade8), 32'd0);

    // random requests from idle
    for (int i = 0; i < 15; i++) begin
      r = $urandom_range(0, 5);
      if (r < 4) tc = 4'(1 << r);
      else if (r == 4) tc = 4'b0000;
      else tc = 4'($urandom_range(0, 15));
      run_ramp($sformatf("rnd%0d", i), tc,
               $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lighting_controller_gen2.md
LIGHTING_CONTROLLER_GEN2 -- requirements
Module: lighting_controller_gen2

Interface
REQ-001 Parameter NUM_LIGHTS, default 16, SHALL set the number of lamp outputs (legal range 1..2^LVL_W).
REQ-002 Parameter LVL_W, default 4, SHALL set the width of the level, length and shade fields.
REQ-003 Parameter RAMP_DIV, default 4, SHALL set the clock cycles per ramp step (legal range >= 2).
REQ-004 Derived CNT_W = clog2(NUM_LIGHTS+1) SHALL set the width of lightnum.
REQ-005 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  in  1  SHALL be the request strobe; it is sampled on every rising edge.
REQ-008 tcode  in  4  SHALL be the one-hot time code: 0001 morning, 0010 noon, 0100 evening, 1000 night.
REQ-009 ulight  in  LVL_W  SHALL be the user shade level, used in noon mode.
REQ-010 length  in  LVL_W  SHALL be the room length, i.e. the requested lamp count.
REQ-011 wshade  out  LVL_W  SHALL be the current window-shade position (0 = closed, all-ones = open).
REQ-012 lightnum  out  CNT_W  SHALL be the current count of lamps on.
REQ-013 lightstate  out  NUM_LIGHTS  SHALL be a thermometer mask where bit i = (i < lightnum).
REQ-014 busy  out  1  SHALL be high while the state is RAMP.
REQ-015 done  out  1  SHALL be a registered, one-cycle pulse that marks target reached.

Function
REQ-016 On an edge with req=1, the block SHALL latch the targets from tcode, ulight and length.
REQ-017 Morning targets SHALL be shade = 2^LVL_W-1 and lights = 0.
REQ-018 Noon targets SHALL be shade = ulight and lights = 0.
REQ-019 Evening targets SHALL be shade = 0 and lights = min(length, NUM_LIGHTS).
REQ-020 Night targets SHALL be shade = 0 and lights = min(length>>1, NUM_LIGHTS).
REQ-021 For tcode 0000 or any non-one-hot value, the shade target SHALL be the current wshade (hold) and the light target SHALL be 0.
REQ-022 Width rules: the min() compare SHALL be done zero-extended to max(LVL_W, CNT_W); no truncation of NUM_LIGHTS is allowed.
REQ-023 The FSM SHALL have two states: IDLE and RAMP.
REQ-024 IDLE with req=1 SHALL go to RAMP on that edge and clear the divider to 0.
REQ-025 In RAMP, the divider SHALL increment each cycle; when divider = RAMP_DIV-1 it SHALL wrap to 0 and a step occurs.
REQ-026 On a step, lightnum SHALL move +/-1 toward its target and wshade SHALL move +/-1 toward its target, independently; a field already at target stays.
REQ-027 In RAMP, if lightnum and wshade both equal their targets and req=0, the block SHALL set done=1 for one cycle and return to IDLE; no step occurs on that edge.
REQ-028 Latency: for a ramp of N steps (N = max of the light and shade distances) requested at edge k, step j SHALL occur at edge k+j*RAMP_DIV and done SHALL be high after edge k+N*RAMP_DIV+1.
REQ-029 A zero-distance request at edge k SHALL give done after edge k+1.
REQ-030 req during RAMP (retarget) SHALL re-latch the targets without clearing the divider and without moving the outputs back.
REQ-031 A step on the same edge as a retarget SHALL use the old targets.
REQ-032 If req and completion coincide on the same edge, req SHALL win: the block stays in RAMP and done is not asserted.
REQ-033 lightstate SHALL be derived combinationally from the registered lightnum only.
REQ-034 Outputs SHALL never overshoot a target, and SHALL never exceed NUM_LIGHTS or 2^LVL_W-1.

Reset
REQ-035 While rst_n=0, the block SHALL be in IDLE, and wshade, lightnum, lightstate, busy, done, the targets and the divider SHALL all be 0, asynchronously.
REQ-036 Reset asserted mid-ramp SHALL abort the ramp with no done pulse.
REQ-037 The first req after rst_n deasserts SHALL be honoured normally.

Verification (defaults unless noted)
REQ-038 Reset, then req with tcode=0100, length=4 at edge k -> lightnum = 1, 2, 3, 4 at k+4, k+8, k+12, k+16; lightstate=0x000F; done after k+17; busy low after k+17.
REQ-039 From reset, req with tcode=0001 -> wshade ramps 0 to 15 in 15 steps; lightnum stays 0; done after k+61.
REQ-040 NUM_LIGHTS=8, tcode=0100, length=15 -> lightnum saturates at 8, lightstate=0xFF.
REQ-041 Evening with length=8; after 3 steps, req with tcode=1000, length=8 -> target becomes 4; one more step to 4, then done; the divider phase is preserved.
REQ-042 rst_n pulsed low mid-ramp -> all outputs 0 immediately and no done; a new req after release ramps from 0.
REQ-043 From lights=4, shade=7, req with tcode=0011 -> lights ramp to 0, wshade holds 7, done after 4 steps.
